// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - memory-mapped switch/push-button input buffer with debounce and sticky edge capture
// Optional macro INPUT_BUFFER_IRQ_EN adds a registered o_irq output.
module input_buffer #(
  parameter int SW_WIDTH        = 18,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [31:0]         i_io_sw,
  input  logic [NUM_KEYS-1:0] i_io_btn,
  input  logic [31:0]         i_io_addr,
  input  logic [2:0]          i_funct3,
  input  logic                f_io_rden,
  output logic [31:0]         o_ld_data,
`ifdef INPUT_BUFFER_IRQ_EN
  output logic                o_irq,
`endif
  output logic                o_ld_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] r_sw_s1, r_sw_s2;
  logic [NUM_KEYS-1:0] r_btn_s1, r_btn_s2;
  logic [NUM_KEYS-1:0] r_key_lvl;
  logic [NUM_KEYS-1:0] r_edge;
  logic [CW-1:0]       r_cnt [NUM_KEYS];

  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_lvl_next;
  logic [NUM_KEYS-1:0] w_rise;
  logic [CW-1:0]       w_cnt_next [NUM_KEYS];
  logic                w_sel_edge;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_sw_unused;
  logic [31:0]         w_addr_unused;

  assign w_sw_unused   = i_io_sw;
  assign w_addr_unused = i_io_addr;

  assign w_pressed = ~r_btn_s2;

  // A level change is accepted only on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    w_lvl_next = r_key_lvl;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_cnt_next[k] = '0;
      if (w_pressed[k] != r_key_lvl[k]) begin
        if (r_cnt[k] == CNT_MAX) begin
          w_lvl_next[k] = w_pressed[k];
        end else begin
          w_cnt_next[k] = r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_rise     = w_lvl_next & ~r_key_lvl;
  assign w_sel_edge = f_io_rden && (i_io_addr[7:4] == 4'h2);

  always_comb begin
    w_word = '0;
    case (i_io_addr[7:4])
      4'h0:    w_word = 32'(r_sw_s2);
      4'h1:    w_word = 32'(r_key_lvl);
      4'h2:    w_word = 32'(r_edge);
      default: w_word = '0;
    endcase
  end

  assign w_byte = w_word[{i_io_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{i_io_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = '0;
    case (i_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '1;
      r_btn_s2   <= '1;
      r_key_lvl  <= '0;
      r_edge     <= '0;
      o_ld_data  <= '0;
      o_ld_valid <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_sw_s1   <= i_io_sw[SW_WIDTH-1:0];
      r_sw_s2   <= r_sw_s1;
      r_btn_s1  <= i_io_btn;
      r_btn_s2  <= r_btn_s1;
      r_key_lvl <= w_lvl_next;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_cnt[k] <= w_cnt_next[k];
      end
      // New edges win over the clear-on-read so a same-cycle press is never lost.
      r_edge     <= (w_sel_edge ? '0 : r_edge) | w_rise;
      o_ld_valid <= f_io_rden;
      if (f_io_rden) begin
        o_ld_data <= w_load;
      end
    end
  end

`ifdef INPUT_BUFFER_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |r_edge;
    end
  end
`endif

endmodule

// File: tb/tb_input_buffer.sv
// tb/tb_input_buffer.sv - self-checking bench for input_buffer (vector table, hand sequences, randomized model compare)
module tb_input_buffer;
  localparam int SW = 18;
  localparam int NK = 4;
  localparam int D  = 4;
  localparam logic [31:0] BASE = 32'h1000_7800;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   sw;
  logic [NK-1:0] btn;
  logic [31:0]   addr;
  logic [2:0]    f3;
  logic          rden;
  logic [31:0]   ld_data;
  logic          ld_valid;
`ifdef INPUT_BUFFER_IRQ_EN
  logic          irq;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  input_buffer #(.SW_WIDTH(SW), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_io_sw    (sw),
    .i_io_btn   (btn),
    .i_io_addr  (addr),
    .i_funct3   (f3),
    .f_io_rden  (rden),
    .o_ld_data  (ld_data),
`ifdef INPUT_BUFFER_IRQ_EN
    .o_irq      (irq),
`endif
    .o_ld_valid (ld_valid)
  );

  always #5 clk = ~clk;

  // Reference state: synchronizers as plain delay lines, debounce as a sample history window.
  logic [SW-1:0] m_sw1, m_sw2;
  logic [NK-1:0] m_btn1, m_btn2, m_lvl, m_edge;
  logic [D-1:0]  m_hist [NK];
  logic [31:0]   m_data;
  logic          m_valid, m_irq;

  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] w);
    longint v;
    longint off;
    v = 0;
    case (fn)
      3'd0, 3'd4: begin
        off = longint'(a % 4);
        v = (longint'(w) >> (8 * off)) % 256;
        if (fn == 3'd0 && v > 127) v = v - 256;
      end
      3'd1, 3'd5: begin
        off = longint'((a / 2) % 2);
        v = (longint'(w) >> (16 * off)) % 65536;
        if (fn == 3'd1 && v > 32767) v = v - 65536;
      end
      3'd2: v = longint'(w);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_update();
    logic [31:0]   word;
    logic [NK-1:0] pressed, new_lvl;
    if (reset) begin
      m_sw1 = '0; m_sw2 = '0; m_btn1 = '1; m_btn2 = '1;
      m_lvl = '0; m_edge = '0; m_data = '0; m_valid = 1'b0; m_irq = 1'b0;
      for (int k = 0; k < NK; k++) m_hist[k] = '0;
    end else begin
      case ((addr / 16) % 16)
        0:       word = 32'(m_sw2);
        1:       word = 32'(m_lvl);
        2:       word = 32'(m_edge);
        default: word = 0;
      endcase
      pressed = ~m_btn2;
      new_lvl = m_lvl;
      for (int k = 0; k < NK; k++) begin
        m_hist[k] = {m_hist[k][D-2:0], pressed[k]};
        if (m_hist[k] == {D{~m_lvl[k]}}) new_lvl[k] = ~m_lvl[k];
      end
      m_irq = |m_edge;
      m_valid = rden;
      if (rden) m_data = ref_load(f3, addr, word);
      m_edge = ((rden && ((addr / 16) % 16) == 2) ? '0 : m_edge) | (new_lvl & ~m_lvl);
      m_lvl = new_lvl;
      m_sw2 = m_sw1; m_sw1 = sw[SW-1:0];
      m_btn2 = m_btn1; m_btn1 = btn;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("model valid", 32'(ld_valid), 32'(m_valid));
    check("model data", ld_data, m_data);
`ifdef INPUT_BUFFER_IRQ_EN
    check("model irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic idle(input int n);
    rden = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read(input logic [7:0] off, input logic [2:0] fn, input logic [31:0] exp, input string name);
    addr = BASE | 32'(off);
    f3 = fn;
    rden = 1'b1;
    step();
    check({name, " valid"}, 32'(ld_valid), 32'd1);
    check(name, ld_data, exp);
  endtask

  typedef struct {
    logic [31:0] sw;
    logic [7:0]  off;
    logic [2:0]  fn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h0002_8081, 8'h00, 3'd2, 32'h0002_8081};
    vecs[1]  = '{32'h0002_8081, 8'h00, 3'd0, 32'hFFFF_FF81};
    vecs[2]  = '{32'h0002_8081, 8'h00, 3'd4, 32'h0000_0081};
    vecs[3]  = '{32'h0002_8081, 8'h00, 3'd1, 32'hFFFF_8081};
    vecs[4]  = '{32'h0002_8081, 8'h02, 3'd5, 32'h0000_0002};
    vecs[5]  = '{32'h0002_8081, 8'h01, 3'd0, 32'hFFFF_FF80};
    vecs[6]  = '{32'h0002_8081, 8'h03, 3'd1, 32'h0000_0002};
    vecs[7]  = '{32'h0002_8081, 8'h03, 3'd2, 32'h0002_8081};
    vecs[8]  = '{32'h0002_8081, 8'h00, 3'd3, 32'h0000_0000};
    vecs[9]  = '{32'hFFFF_FFFF, 8'h00, 3'd2, 32'h0003_FFFF};
    vecs[10] = '{32'hFFFF_FFFF, 8'h02, 3'd1, 32'h0000_0003};
    vecs[11] = '{32'hFFFF_FFFF, 8'h50, 3'd2, 32'h0000_0000};

    // Reset held with a read pending: no valid, data zero.
    reset = 1'b1; sw = 32'h3FFFF; btn = '1; rden = 1'b1; addr = BASE; f3 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset valid", 32'(ld_valid), 32'd0);
      check("reset data", ld_data, 32'd0);
    end
    reset = 1'b0;
    read(8'h00, 3'd2, 32'h0, "post-reset sw");
    read(8'h10, 3'd2, 32'h0, "post-reset key");
    read(8'h20, 3'd2, 32'h0, "post-reset edge");

    for (int i = 0; i < 12; i++) begin
      sw = vecs[i].sw;
      idle(3);
      read(vecs[i].off, vecs[i].fn, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Glitch of three cycles must not move the debounced level.
    sw = 32'h0; btn = 4'hF; idle(6);
    btn = 4'hE; idle(3);
    btn = 4'hF; idle(8);
    read(8'h10, 3'd2, 32'h0, "glitch key");
    read(8'h20, 3'd2, 32'h0, "glitch edge");

    // Held press: level visible 2+4 cycles after the press.
    btn = 4'hE; idle(6);
    read(8'h10, 3'd2, 32'h1, "debounced key0");
    idle(2);
    btn = 4'hF; idle(8);
    read(8'h10, 3'd2, 32'h0, "released key0");
    read(8'h20, 3'd2, 32'h1, "edge key0");
    read(8'h20, 3'd2, 32'h0, "edge cleared");

    btn = 4'hB; idle(6);
    btn = 4'hF; idle(8);
    read(8'h20, 3'd2, 32'h4, "edge key2");
    read(8'h20, 3'd2, 32'h0, "edge key2 cleared");

    // Key 1 rises on the same edge as the clearing read.
    btn = 4'hD; idle(5);
    read(8'h20, 3'd2, 32'h0, "clear-race read");
    read(8'h20, 3'd2, 32'h2, "clear-race kept");
    btn = 4'hF; idle(8);

    sw = 32'h0000_1234; btn = 4'h7; idle(8);
    read(8'h00, 3'd2, 32'h0000_1234, "b2b sw");
    read(8'h50, 3'd2, 32'h0, "b2b unmapped");
    read(8'h10, 3'd2, 32'h8, "b2b key");
    idle(1);
    check("b2b end valid", 32'(ld_valid), 32'd0);

    rden = 1'b1; addr = BASE; reset = 1'b1;
    step();
    check("mid-read reset valid", 32'(ld_valid), 32'd0);
    reset = 1'b0; btn = 4'hF; idle(4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) sw = $urandom;
      rden = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: addr = BASE | 32'h00;
        1: addr = BASE | 32'h10;
        2: addr = BASE | 32'h20;
        default: addr = BASE | 32'h50;
      endcase
      addr = addr | 32'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
